// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the sequential matrix-multiply engine.
//   state_t  - FSM state encoding used by matmul_seq
//   addr_idx - word index of element [row][col] of a row-major n x n matrix at base
package matmul_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_RDC,
    S_LDC,
    S_RDA,
    S_RDB,
    S_MAC,
    S_WR,
    S_DONE
  } state_t;

  function automatic int unsigned addr_idx(input int unsigned base,
                                           input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned n);
    return base + row * n + col;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: DW-bit accumulator for one C element.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (acc <= 0)
//   clr       - acc <= 0
//   ld        - acc <= din (preload with existing C value)
//   mac_en    - acc <= acc + a*din, truncated to DW bits
//   a, din    - multiplicand (latched A element) and memory read data
//   sum       - acc + a*din, the value acc takes on a MAC step
module matmul_mac #(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 ld,
  input  logic                 mac_en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] sum
);

  logic signed [DW-1:0]   acc;
  logic signed [2*DW-1:0] prod;

  // Only the low DW bits of the product matter; two's-complement wrap.
  assign prod = a * din;
  assign sum  = acc + prod[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (ld) begin
      acc <= din;
    end else if (mac_en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// matmul_seq: sequential NxN matrix multiply, C = A*B (mode 0) or C = C + A*B (mode 1),
// operating on a single-port word memory. One memory access per cycle at most.
// Ports:
//   clk, rst              - clock, synchronous active-high reset (aborts any job)
//   start, mode           - job request and accumulate select, sampled in IDLE only
//   busy, done            - job running / one-cycle completion pulse
//   mem_addr, mem_rd_en   - word address and read request (data returns next cycle)
//   mem_rdata             - read data
//   mem_wr_en, mem_wdata  - write strobe and data
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int N      = 3,
  parameter int DW     = 32,
  parameter int AW     = 8,
  parameter int A_BASE = 0,
  parameter int B_BASE = 9,
  parameter int C_BASE = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t               state;
  logic                 mode_q;
  logic [CW-1:0]        i, j, k;
  logic [CW-1:0]        ni, nj, kn;
  logic signed [DW-1:0] a_reg;
  logic signed [DW-1:0] mac_sum;
  logic [AW-1:0]        a_addr, a_addr_nx, b_addr, c_addr, c_addr_nx;
  logic                 last_elem;

  // Next (i, j) in row-major order, used when leaving WR.
  always_comb begin
    nj = j + 1'b1;
    ni = i;
    if (j == LAST) begin
      nj = '0;
      ni = i + 1'b1;
    end
  end

  assign kn        = k + 1'b1;
  assign last_elem = (i == LAST) && (j == LAST);

  assign a_addr    = AW'(addr_idx(A_BASE, 32'(i), 32'(k), N));
  assign a_addr_nx = AW'(addr_idx(A_BASE, 32'(i), 32'(kn), N));
  assign b_addr    = AW'(addr_idx(B_BASE, 32'(k), 32'(j), N));
  assign c_addr    = AW'(addr_idx(C_BASE, 32'(i), 32'(j), N));
  assign c_addr_nx = AW'(addr_idx(C_BASE, 32'(ni), 32'(nj), N));

  matmul_mac #(.DW(DW)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == S_CLR),
    .ld     (state == S_LDC),
    .mac_en (state == S_MAC),
    .a      (a_reg),
    .din    (mem_rdata),
    .sum    (mac_sum)
  );

  // Memory strobes and address are registered: they are set on the edge that
  // enters the state performing the access, so they are valid throughout it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mode_q    <= 1'b0;
      a_reg     <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            busy   <= 1'b1;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            if (mode) begin
              state     <= S_RDC;
              mem_rd_en <= 1'b1;
              mem_addr  <= AW'(C_BASE);
            end else begin
              state <= S_CLR;
            end
          end
        end
        S_CLR, S_LDC: begin
          state     <= S_RDA;
          mem_rd_en <= 1'b1;
          mem_addr  <= a_addr;
        end
        S_RDC: state <= S_LDC;
        S_RDA: begin
          state     <= S_RDB;
          mem_rd_en <= 1'b1;
          mem_addr  <= b_addr;
        end
        S_RDB: begin
          a_reg <= mem_rdata;
          state <= S_MAC;
        end
        S_MAC: begin
          if (k != LAST) begin
            k         <= kn;
            state     <= S_RDA;
            mem_rd_en <= 1'b1;
            mem_addr  <= a_addr_nx;
          end else begin
            // Write the value the accumulator takes on this final MAC step.
            k         <= '0;
            state     <= S_WR;
            mem_wr_en <= 1'b1;
            mem_addr  <= c_addr;
            mem_wdata <= mac_sum;
          end
        end
        S_WR: begin
          if (last_elem) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            i <= ni;
            j <= nj;
            if (mode_q) begin
              state     <= S_RDC;
              mem_rd_en <= 1'b1;
              mem_addr  <= c_addr_nx;
            end else begin
              state <= S_CLR;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: directed bench for matmul_seq (N=3 main instance, N=2 second instance).
// A reference model computes every C element from the memory image with plain
// 32-bit arithmetic; a monitor compares each DUT write against the model's queue.
module tb_matmul_seq;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, mode;
  logic          busy, done, mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, mem_wdata;
  logic [DW-1:0] mem [256];

  logic          start2, mode2;
  logic          busy2, done2, mem_rd_en2, mem_wr_en2;
  logic [AW-1:0] mem_addr2;
  logic [DW-1:0] mem_rdata2, mem_wdata2;
  logic [DW-1:0] mem2 [256];

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];

  always #5 clk = ~clk;

  matmul_seq #(.N(3), .DW(DW), .AW(AW), .A_BASE(0), .B_BASE(9), .C_BASE(18)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  matmul_seq #(.N(2), .DW(DW), .AW(AW), .A_BASE(0), .B_BASE(4), .C_BASE(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .busy(busy2), .done(done2),
    .mem_addr(mem_addr2), .mem_rd_en(mem_rd_en2), .mem_rdata(mem_rdata2),
    .mem_wr_en(mem_wr_en2), .mem_wdata(mem_wdata2)
  );

  // Single-port memories: read data registered, available the cycle after rd_en.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] = mem_wdata;
    if (mem_rd_en2) mem_rdata2 <= mem2[mem_addr2];
    if (mem_wr_en2) mem2[mem_addr2] = mem_wdata2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: C[i][j] = (md ? C[i][j] : 0) + sum_k A[i][k]*B[k][j], low 32 bits.
  function automatic logic [31:0] model_c(input int n, input int ab, input int bb, input int cb,
                                          input bit md, input int i, input int j,
                                          input logic [31:0] m [256]);
    logic [31:0] s;
    s = md ? m[cb + i*n + j] : 32'd0;
    for (int kk = 0; kk < n; kk++) s = s + m[ab + i*n + kk] * m[bb + kk*n + j];
    return s;
  endfunction

  task automatic load_model(input bit md);
    exp_addr.delete();
    exp_data.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        exp_addr.push_back(AW'(18 + r*3 + c));
        exp_data.push_back(model_c(3, 0, 9, 18, md, r, c, mem));
      end
  endtask

  // Write monitor for the N=3 instance, every cycle.
  always @(negedge clk) begin
    chk("rd_wr_exclusive", 32'(mem_rd_en & mem_wr_en), 32'd0);
    if (mem_wr_en) begin
      wr_count++;
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d, none expected", mem_addr, mem_wdata);
      end else begin
        chk("wr_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
        chk("wr_data", mem_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic run_job(input bit md, input int exp_busy, input int poke_cyc, input string tag);
    int cyc, bcnt, w0;
    load_model(md);
    w0 = wr_count;
    @(negedge clk);
    start = 1'b1;
    mode  = md;
    @(negedge clk);
    start = 1'b0;
    mode  = ~md;
    cyc  = 1;
    bcnt = 0;
    while (!done && cyc < 1000) begin
      if (busy) bcnt++;
      start = (cyc == poke_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_busy + 1));
    chk({tag, "_write_count"}, 32'(wr_count - w0), 32'd9);
    chk({tag, "_model_drained"}, 32'(exp_addr.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic load_ab_seq();
    for (int n = 0; n < 256; n++) mem[n] = '0;
    for (int n = 0; n < 9; n++) begin
      mem[n]     = 32'(n + 1);
      mem[9 + n] = 32'(n + 10);
    end
  endtask

  initial begin
    int cyc, bcnt, w0;
    int ab_exp[9] = '{84, 90, 96, 201, 216, 231, 318, 342, 366};
    int n2_exp[4] = '{19, 22, 43, 50};
    rst = 1'b1; start = 1'b0; mode = 1'b0; start2 = 1'b0; mode2 = 1'b0;
    for (int n = 0; n < 256; n++) begin mem[n] = '0; mem2[n] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Identity A, B = 1..9
    for (int n = 0; n < 9; n++) mem[9 + n] = 32'(n + 1);
    mem[0] = 1; mem[4] = 1; mem[8] = 1;
    run_job(1'b0, 99, 0, "ident");
    for (int n = 0; n < 9; n++) chk("ident_c", mem[18 + n], 32'(n + 1));

    // A=1..9, B=10..18 with a stray start at cycle 50
    load_ab_seq();
    run_job(1'b0, 99, 50, "ab_m0");
    for (int n = 0; n < 9; n++) chk("ab_m0_c", mem[18 + n], 32'(ab_exp[n]));

    // Accumulate mode doubles C
    run_job(1'b1, 108, 0, "ab_m1");
    chk("ab_m1_c00", mem[18], 32'd168);
    chk("ab_m1_c22", mem[26], 32'd732);

    // Truncating wrap
    for (int n = 0; n < 256; n++) mem[n] = '0;
    mem[0] = 32'h8000_0000;
    mem[9] = 32'd2;
    mem[18] = 32'd5;
    run_job(1'b0, 99, 0, "wrap");
    chk("wrap_c00", mem[18], 32'd0);

    // Reset at cycle 40 aborts, then a clean restart
    load_ab_seq();
    load_model(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_en", 32'(mem_wr_en), 32'd0);
    exp_addr.delete();
    exp_data.delete();
    w0 = wr_count;
    repeat (30) @(negedge clk);
    chk("abort_no_writes", 32'(wr_count - w0), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    run_job(1'b0, 99, 0, "restart");
    for (int n = 0; n < 9; n++) chk("restart_c", mem[18 + n], 32'(ab_exp[n]));

    // N=2 instance
    for (int n = 0; n < 4; n++) begin
      mem2[n]     = 32'(n + 1);
      mem2[4 + n] = 32'(n + 5);
    end
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc  = 1;
    bcnt = 0;
    while (!done2 && cyc < 500) begin
      if (busy2) bcnt++;
      @(negedge clk);
      cyc++;
    end
    chk("n2_busy_cycles", 32'(bcnt), 32'd32);
    chk("n2_done_cycle", 32'(cyc), 32'd33);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        chk("n2_model", mem2[8 + r*2 + c], model_c(2, 0, 4, 8, 1'b0, r, c, mem2));
        chk("n2_c", mem2[8 + r*2 + c], 32'(n2_exp[r*2 + c]));
      end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
